// File: rtl/fp_fflags_commit_unit_pkg.sv
// FP exception-flag types and default sizing shared by the fflags commit path.
// Provides the fflags type, RISC-V flag bit positions and active-list pointer type.
package fp_fflags_commit_unit_pkg;

    localparam int DEF_FP_ISSUE_WIDTH        = 2;
    localparam int DEF_COMMIT_WIDTH          = 4;
    localparam int DEF_ACTIVE_LIST_ENTRY_NUM = 64;
    localparam int DEF_FFLAGS_WIDTH          = 5;

    localparam int ACTIVE_LIST_INDEX_WIDTH =
        $clog2(DEF_ACTIVE_LIST_ENTRY_NUM);

    typedef logic [DEF_FFLAGS_WIDTH-1:0] fflags_t;
    typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0] active_list_index_path_t;

    localparam int FFLAGS_NV = 4;
    localparam int FFLAGS_DZ = 3;
    localparam int FFLAGS_OF = 2;
    localparam int FFLAGS_UF = 1;
    localparam int FFLAGS_NX = 0;

endpackage

// File: rtl/fp_fflags_table.sv
// Per-active-list-entry {valid, flags} store: multi-port write, multi-port
// read with same-cycle write bypass, read-clears-valid, flush clears all.
module fp_fflags_table
    import fp_fflags_commit_unit_pkg::*;
#(
    parameter int WR_PORTS = DEF_FP_ISSUE_WIDTH,
    parameter int RD_PORTS = DEF_COMMIT_WIDTH,
    parameter int ENTRIES  = DEF_ACTIVE_LIST_ENTRY_NUM,
    parameter int FW       = DEF_FFLAGS_WIDTH,
    localparam int PTR_W   = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [WR_PORTS-1:0] wr_en,
    input  logic [PTR_W-1:0]    wr_ptr   [WR_PORTS],
    input  logic [FW-1:0]       wr_flags [WR_PORTS],
    input  logic [RD_PORTS-1:0] rd_en,
    input  logic [PTR_W-1:0]    rd_ptr   [RD_PORTS],
    output logic [RD_PORTS-1:0] rd_hit,
    output logic [FW-1:0]       rd_flags [RD_PORTS]
);

    logic [ENTRIES-1:0] valid_q;
    logic [FW-1:0]      flags_q [ENTRIES];
    logic               wr_clash;

    // A write landing this cycle on the read pointer overrides the stored copy.
    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_hit[k]   = 1'b0;
            rd_flags[k] = '0;
            if (rd_en[k]) begin
                if (valid_q[rd_ptr[k]]) begin
                    rd_hit[k]   = 1'b1;
                    rd_flags[k] = flags_q[rd_ptr[k]];
                end
                for (int i = 0; i < WR_PORTS; i++) begin
                    if (wr_en[i] && (wr_ptr[i] == rd_ptr[k])) begin
                        rd_hit[k]   = 1'b1;
                        rd_flags[k] = wr_flags[i];
                    end
                end
            end
        end
    end

    // Clears are applied after sets so a bypassed entry ends invalid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (wr_en[i]) valid_q[wr_ptr[i]] <= 1'b1;
            end
            for (int k = 0; k < RD_PORTS; k++) begin
                if (rd_hit[k]) valid_q[rd_ptr[k]] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (wr_en[i]) flags_q[wr_ptr[i]] <= wr_flags[i];
            end
        end
    end

    always_comb begin
        wr_clash = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_ptr[i] == wr_ptr[j]))
                    wr_clash = 1'b1;
            end
        end
    end

    a_no_wr_clash: assert property (
        @(posedge clk) disable iff (rst) !wr_clash);

endmodule

// File: rtl/fp_fflags_commit_unit.sv
// Accumulates fflags of retiring FP ops into the architectural fflags
// register; services CSR writes, flush invalidation, fs_dirty tracking.
module fp_fflags_commit_unit
    import fp_fflags_commit_unit_pkg::*;
#(
    parameter int FP_ISSUE_WIDTH        = DEF_FP_ISSUE_WIDTH,
    parameter int COMMIT_WIDTH          = DEF_COMMIT_WIDTH,
    parameter int ACTIVE_LIST_ENTRY_NUM = DEF_ACTIVE_LIST_ENTRY_NUM,
    parameter int FFLAGS_WIDTH          = DEF_FFLAGS_WIDTH,
    localparam int PTR_W = $clog2(ACTIVE_LIST_ENTRY_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FP_ISSUE_WIDTH-1:0] wr_en,
    input  logic [PTR_W-1:0]          wr_ptr       [FP_ISSUE_WIDTH],
    input  logic [FFLAGS_WIDTH-1:0]   wr_fflags    [FP_ISSUE_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]   commit_valid,
    input  logic [COMMIT_WIDTH-1:0]   commit_is_fp,
    input  logic [PTR_W-1:0]          commit_ptr   [COMMIT_WIDTH],
    input  logic                      flush_all,
    input  logic                      csr_wr_en,
    input  logic [FFLAGS_WIDTH-1:0]   csr_wr_data,
    output logic [FFLAGS_WIDTH-1:0]   fflags_out,
    output logic                      fs_dirty,
    output logic                      flags_updated
);

    logic [COMMIT_WIDTH-1:0] rd_en;
    logic [COMMIT_WIDTH-1:0] hit;
    logic [COMMIT_WIDTH-1:0] miss;
    logic [FFLAGS_WIDTH-1:0] rd_flags [COMMIT_WIDTH];
    logic [FFLAGS_WIDTH-1:0] acc;
    logic [FFLAGS_WIDTH-1:0] fflags_d;

    assign rd_en = commit_valid & commit_is_fp;
    assign miss  = rd_en & ~hit;

    fp_fflags_table #(
        .WR_PORTS (FP_ISSUE_WIDTH),
        .RD_PORTS (COMMIT_WIDTH),
        .ENTRIES  (ACTIVE_LIST_ENTRY_NUM),
        .FW       (FFLAGS_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_all),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .wr_flags (wr_fflags),
        .rd_en    (rd_en),
        .rd_ptr   (commit_ptr),
        .rd_hit   (hit),
        .rd_flags (rd_flags)
    );

    // Non-contributing slots read back zero, so a plain OR suffices.
    always_comb begin
        acc = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) acc |= rd_flags[k];
    end

    assign fflags_d = csr_wr_en ? csr_wr_data : (fflags_out | acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_out    <= '0;
            fs_dirty      <= 1'b0;
            flags_updated <= 1'b0;
        end else begin
            fflags_out    <= fflags_d;
            fs_dirty      <= fs_dirty | csr_wr_en | (|hit);
            flags_updated <= (fflags_d != fflags_out);
        end
    end

    a_no_commit_miss: assert property (
        @(posedge clk) disable iff (rst) !(|miss));

    a_csr_serialized: assert property (
        @(posedge clk) disable iff (rst) !(csr_wr_en && (|rd_en)));

endmodule
